// File: rtl/issue_queue.sv
// issue_queue: DEPTH-entry reservation station with CDB wakeup, a dispatch-time
// CDB bypass, and one registered issue slot feeding the ALU.
// Build option: define ISSUE_AGE_ORDER_EN to issue the oldest ready entry
// (tracked with an age matrix); otherwise the lowest-index ready entry issues.
module issue_queue #(
  parameter int DEPTH   = 8,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [31:0]              disp_v1,
  input  logic [31:0]              disp_v2,
  input  logic                     disp_q1b,
  input  logic                     disp_q2b,
  input  logic [ROB_W-1:0]         disp_q1,
  input  logic [ROB_W-1:0]         disp_q2,
  input  logic [ROB_W-1:0]         disp_rob_id,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [31:0]              iss_opr1,
  output logic [31:0]              iss_opr2,
  output logic [ROB_W-1:0]         iss_rob_id,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Returns {hit, data} for a tag; scanning high-to-low lets the lowest port win.
  function automatic logic [32:0] cdb_lookup(
    input logic [ROB_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*ROB_W-1:0] tags,
    input logic [NUM_CDB*32-1:0]    data
  );
    logic [32:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*ROB_W +: ROB_W] == tag)) begin
        res = {1'b1, data[k*32 +: 32]};
      end
    end
    return res;
  endfunction

  // Entry storage
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] q1b_q, q1b_d;
  logic [DEPTH-1:0] q2b_q, q2b_d;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [OP_W-1:0]  op_d  [DEPTH];
  logic [31:0]      v1_q  [DEPTH];
  logic [31:0]      v1_d  [DEPTH];
  logic [31:0]      v2_q  [DEPTH];
  logic [31:0]      v2_d  [DEPTH];
  logic [ROB_W-1:0] q1_q  [DEPTH];
  logic [ROB_W-1:0] q1_d  [DEPTH];
  logic [ROB_W-1:0] q2_q  [DEPTH];
  logic [ROB_W-1:0] q2_d  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [ROB_W-1:0] rob_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // Issue slot
  logic             iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]  iss_op_q, iss_op_d;
  logic [31:0]      iss_opr1_q, iss_opr1_d;
  logic [31:0]      iss_opr2_q, iss_opr2_d;
  logic [ROB_W-1:0] iss_rob_q, iss_rob_d;

`ifdef ISSUE_AGE_ORDER_EN
  // older_q[i][j] = 1 when entry i was dispatched before entry j
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] older_col [DEPTH];
`endif

  logic [DEPTH-1:0] ready;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             disp_fire;
  logic             slot_free;
  logic             iss_fire;
  logic [32:0]      disp_m1, disp_m2;
  logic [32:0]      wake1 [DEPTH];
  logic [32:0]      wake2 [DEPTH];

  assign ready      = busy_q & ~q1b_q & ~q2b_q;
  assign disp_ready = (count_q < DEPTH_C);
  assign disp_fire  = disp_valid && disp_ready;
  assign slot_free  = !iss_valid_q || iss_ready;
  assign iss_fire   = slot_free && sel_found;
  assign disp_m1    = cdb_lookup(disp_q1, cdb_valid, cdb_tag, cdb_data);
  assign disp_m2    = cdb_lookup(disp_q2, cdb_valid, cdb_tag, cdb_data);

  // Per-entry CDB match on the stored producer tags
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = cdb_lookup(q1_q[i], cdb_valid, cdb_tag, cdb_data);
      wake2[i] = cdb_lookup(q2_q[i], cdb_valid, cdb_tag, cdb_data);
    end
  end

`ifdef ISSUE_AGE_ORDER_EN
  // Transpose the age matrix so each entry sees which entries are older than it
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_col[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_col[i][j] = older_q[j][i];
      end
    end
  end

  // Pick the single ready entry that no other ready entry is older than
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && ready[i] && ((ready & older_col[i]) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`else
  // Pick the lowest-index ready entry
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`endif

  // Lowest free entry from registered busy flags, so same-cycle frees are not reused
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Next-state: wakeup, issue, dispatch with bypass, count, then flush override
  always_comb begin
    busy_d      = busy_q;
    q1b_d       = q1b_q;
    q2b_d       = q2b_q;
    op_d        = op_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    rob_d       = rob_q;
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_opr1_d  = iss_opr1_q;
    iss_opr2_d  = iss_opr2_q;
    iss_rob_d   = iss_rob_q;
`ifdef ISSUE_AGE_ORDER_EN
    older_d     = older_q;
`endif

    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && q1b_q[i] && wake1[i][32]) begin
        q1b_d[i] = 1'b0;
        v1_d[i]  = wake1[i][31:0];
      end
      if (busy_q[i] && q2b_q[i] && wake2[i][32]) begin
        q2b_d[i] = 1'b0;
        v2_d[i]  = wake2[i][31:0];
      end
    end

    if (slot_free) begin
      iss_valid_d = sel_found;
      if (sel_found) begin
        iss_op_d        = op_q[sel_idx];
        iss_opr1_d      = v1_q[sel_idx];
        iss_opr2_d      = v2_q[sel_idx];
        iss_rob_d       = rob_q[sel_idx];
        busy_d[sel_idx] = 1'b0;
      end
    end

    if (disp_fire && free_found) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = disp_op;
      rob_d[free_idx]  = disp_rob_id;
      q1_d[free_idx]   = disp_q1;
      q2_d[free_idx]   = disp_q2;
      q1b_d[free_idx]  = disp_q1b && !disp_m1[32];
      q2b_d[free_idx]  = disp_q2b && !disp_m2[32];
      v1_d[free_idx]   = (disp_q1b && disp_m1[32]) ? disp_m1[31:0] : disp_v1;
      v2_d[free_idx]   = (disp_q2b && disp_m2[32]) ? disp_m2[31:0] : disp_v2;
`ifdef ISSUE_AGE_ORDER_EN
      for (int j = 0; j < DEPTH; j++) begin
        older_d[free_idx][j] = 1'b0;
        older_d[j][free_idx] = busy_q[j];
      end
`endif
    end

    count_d = count_q + CW'(disp_fire) - CW'(iss_fire);

    if (flush) begin
      busy_d      = '0;
      count_d     = '0;
      iss_valid_d = 1'b0;
`ifdef ISSUE_AGE_ORDER_EN
      for (int i = 0; i < DEPTH; i++) begin
        older_d[i] = '0;
      end
`endif
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      q1b_q       <= '0;
      q2b_q       <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_opr1_q  <= '0;
      iss_opr2_q  <= '0;
      iss_rob_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        q1_q[i]    <= '0;
        q2_q[i]    <= '0;
        rob_q[i]   <= '0;
`ifdef ISSUE_AGE_ORDER_EN
        older_q[i] <= '0;
`endif
      end
    end else begin
      busy_q      <= busy_d;
      q1b_q       <= q1b_d;
      q2b_q       <= q2b_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_opr1_q  <= iss_opr1_d;
      iss_opr2_q  <= iss_opr2_d;
      iss_rob_q   <= iss_rob_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= op_d[i];
        v1_q[i]    <= v1_d[i];
        v2_q[i]    <= v2_d[i];
        q1_q[i]    <= q1_d[i];
        q2_q[i]    <= q2_d[i];
        rob_q[i]   <= rob_d[i];
`ifdef ISSUE_AGE_ORDER_EN
        older_q[i] <= older_d[i];
`endif
      end
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_op     = iss_op_q;
  assign iss_opr1   = iss_opr1_q;
  assign iss_opr2   = iss_opr2_q;
  assign iss_rob_id = iss_rob_q;
  assign count      = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed scenarios for issue_queue with a scoreboard of
// expected issue records (pushed at stimulus time, popped when the slot shows them).
module tb_issue_queue;
  localparam int DEPTH   = 8;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 4;
  localparam int NUM_CDB = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     disp_valid;
  logic                     disp_ready;
  logic [OP_W-1:0]          disp_op;
  logic [31:0]              disp_v1, disp_v2;
  logic                     disp_q1b, disp_q2b;
  logic [ROB_W-1:0]         disp_q1, disp_q2, disp_rob_id;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_tag;
  logic [NUM_CDB*32-1:0]    cdb_data;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [OP_W-1:0]          iss_op;
  logic [31:0]              iss_opr1, iss_opr2;
  logic [ROB_W-1:0]         iss_rob_id;
  logic [$clog2(DEPTH):0]   count;

  issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_q1b(disp_q1b), .disp_q2b(disp_q2b),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_rob_id(disp_rob_id),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_opr1(iss_opr1), .iss_opr2(iss_opr2), .iss_rob_id(iss_rob_id),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      opr1;
    logic [31:0]      opr2;
    logic [ROB_W-1:0] rob;
  } iss_t;

  iss_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic iss_t rec(input int op, input logic [31:0] a, input logic [31:0] b, input int rob);
    iss_t r;
    r.op   = OP_W'(op);
    r.opr1 = a;
    r.opr2 = b;
    r.rob  = ROB_W'(rob);
    return r;
  endfunction

  function automatic iss_t fill_rec(input int r);
    return rec(r, 32'(32'h100 + r), 32'(32'h200 + r), r);
  endfunction

  // Compare the issue slot with the scoreboard head; pop it when do_pop is set
  task automatic check_issue(input string tag, input bit do_pop);
    iss_t e;
    chk({tag, ".sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      if (do_pop) void'(exp_q.pop_front());
      chk({tag, ".valid"}, iss_valid, 1'b1);
      chk({tag, ".op"}, iss_op, e.op);
      chk({tag, ".opr1"}, iss_opr1, e.opr1);
      chk({tag, ".opr2"}, iss_opr2, e.opr2);
      chk({tag, ".rob"}, iss_rob_id, e.rob);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input int op, input logic [31:0] v1, input logic [31:0] v2,
                            input logic q1b, input logic q2b, input int q1, input int q2,
                            input int rob);
    disp_valid  = 1'b1;
    disp_op     = OP_W'(op);
    disp_v1     = v1;
    disp_v2     = v2;
    disp_q1b    = q1b;
    disp_q2b    = q2b;
    disp_q1     = ROB_W'(q1);
    disp_q2     = ROB_W'(q2);
    disp_rob_id = ROB_W'(rob);
  endtask

  task automatic idle_disp();
    disp_valid = 1'b0;
    disp_q1b   = 1'b0;
    disp_q2b   = 1'b0;
  endtask

  task automatic cdb_drive(input int port, input int tag, input logic [31:0] data);
    cdb_valid[port]                = 1'b1;
    cdb_tag[port*ROB_W +: ROB_W]   = ROB_W'(tag);
    cdb_data[port*32 +: 32]        = data;
  endtask

  task automatic cdb_clear();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    iss_ready = 1'b0;
    disp_op = '0; disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0; disp_rob_id = '0;
    idle_disp();
    cdb_clear();

    // Reset state
    tick(); tick();
    chk("rst.count", count, 0);
    chk("rst.iss_valid", iss_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("rst.disp_ready", disp_ready, 1);
    chk("rst.count_rel", count, 0);
    chk("rst.iss_rob", iss_rob_id, 0);

    // S1: present operands issue one edge after becoming ready
    iss_ready = 1'b1;
    drive_disp(2, 32'd5, 32'd7, 0, 0, 0, 0, 3);
    exp_q.push_back(rec(2, 32'd5, 32'd7, 3));
    tick();
    idle_disp();
    chk("s1.count_disp", count, 1);
    chk("s1.not_early", iss_valid, 0);
    tick();
    check_issue("s1", 1);
    chk("s1.count_iss", count, 0);
    tick();
    chk("s1.slot_empty", iss_valid, 0);

    // S2: pending operand woken by cdb port 1 two cycles after dispatch
    drive_disp(3, 32'hDEAD, 32'h22, 1, 0, 6, 0, 1);
    exp_q.push_back(rec(3, 32'h1234, 32'h22, 1));
    tick();
    idle_disp();
    chk("s2.count", count, 1);
    tick();
    cdb_drive(0, 5, 32'h5555);
    cdb_drive(1, 6, 32'h1234);
    tick();
    cdb_clear();
    chk("s2.not_early", iss_valid, 0);
    tick();
    check_issue("s2", 1);
    tick();

    // S2b: both ports match one tag, lowest port data wins
    drive_disp(5, 32'h0101, 32'h0, 0, 1, 0, 8, 5);
    exp_q.push_back(rec(5, 32'h0101, 32'hAAAA, 5));
    tick();
    idle_disp();
    cdb_drive(0, 8, 32'hAAAA);
    cdb_drive(1, 8, 32'hBBBB);
    tick();
    cdb_clear();
    tick();
    check_issue("s2b", 1);
    tick();

    // S3: dispatch bypass from cdb in the same cycle
    drive_disp(6, 32'hBAD, 32'h3, 1, 0, 2, 0, 7);
    cdb_drive(0, 2, 32'd9);
    exp_q.push_back(rec(6, 32'd9, 32'h3, 7));
    tick();
    idle_disp();
    cdb_clear();
    chk("s3.count", count, 1);
    chk("s3.not_early", iss_valid, 0);
    tick();
    check_issue("s3", 1);
    tick();
    chk("s3.slot_empty", iss_valid, 0);
    chk("s3.count_end", count, 0);

    // S4: fill the queue with the ALU stalled, hold the slot, then drain
    iss_ready = 1'b0;
    for (int r = 0; r <= 8; r++) begin
      chk("s4.fill_ready", disp_ready, 1);
      drive_disp(r, 32'(32'h100 + r), 32'(32'h200 + r), 0, 0, 0, 0, r);
`ifdef ISSUE_AGE_ORDER_EN
      exp_q.push_back(fill_rec(r));
`else
      // rob 2 lands in entry 0 (freed by rob 0) and so issues ahead of rob 1
      if (r != 1) exp_q.push_back(fill_rec(r));
      if (r == 2) exp_q.push_back(fill_rec(1));
`endif
      tick();
    end
    idle_disp();
    chk("s4.count_full", count, 8);
    chk("s4.disp_ready_full", disp_ready, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_issue("s4.hold", 0);
    end
    chk("s4.count_hold", count, 8);
    iss_ready = 1'b1;
    check_issue("s4.release", 1);
    tick();
    chk("s4.count_after", count, 7);
    chk("s4.ready_after", disp_ready, 1);
    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() == 0) break;
      check_issue("s4.drain", 1);
      tick();
    end
    chk("s4.drain_done", 32'(exp_q.size()), 0);
    chk("s4.slot_empty", iss_valid, 0);
    chk("s4.count_empty", count, 0);

    // S5: two entries woken together; age order decides which issues first
    drive_disp(1, 32'h0, 32'hA2, 1, 0, 12, 0, 10);
    tick();
    drive_disp(2, 32'h0, 32'hB2, 1, 0, 13, 0, 11);
    tick();
    drive_disp(3, 32'h0, 32'h11, 1, 0, 3, 0, 1);
    cdb_drive(0, 12, 32'hA0);
    exp_q.push_back(rec(1, 32'hA0, 32'hA2, 10));
    tick();
    idle_disp();
    cdb_clear();
    tick();
    check_issue("s5.a", 1);
    chk("s5.count_a", count, 2);
    drive_disp(4, 32'h0, 32'h44, 1, 0, 3, 0, 4);
    tick();
    idle_disp();
    cdb_drive(1, 3, 32'h33);
`ifdef ISSUE_AGE_ORDER_EN
    exp_q.push_back(rec(3, 32'h33, 32'h11, 1));
    exp_q.push_back(rec(4, 32'h33, 32'h44, 4));
`else
    exp_q.push_back(rec(4, 32'h33, 32'h44, 4));
    exp_q.push_back(rec(3, 32'h33, 32'h11, 1));
`endif
    tick();
    cdb_clear();
    tick();
    check_issue("s5.first", 1);
    tick();
    check_issue("s5.second", 1);
    tick();
    cdb_drive(0, 13, 32'hB0);
    exp_q.push_back(rec(2, 32'hB0, 32'hB2, 11));
    tick();
    cdb_clear();
    tick();
    check_issue("s5.b", 1);
    tick();
    chk("s5.count_end", count, 0);
    chk("s5.slot_empty", iss_valid, 0);

    // S6: flush with 5 entries, a valid slot and a concurrent dispatch
    iss_ready = 1'b0;
    for (int r = 0; r < 6; r++) begin
      drive_disp(r, 32'(r), 32'(r + 1), 0, 0, 0, 0, r);
      tick();
    end
    idle_disp();
    chk("s6.count_pre", count, 5);
    chk("s6.slot_pre", iss_valid, 1);
    drive_disp(9, 32'h9, 32'h9, 0, 0, 0, 0, 9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_disp();
    chk("s6.count", count, 0);
    chk("s6.slot", iss_valid, 0);
    chk("s6.disp_ready", disp_ready, 1);
    iss_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("s6.dropped", iss_valid, 0);
    end
    chk("s6.count_end", count, 0);

    // S7: asynchronous reset mid-operation discards entries and the slot
    iss_ready = 1'b0;
    drive_disp(1, 32'h1, 32'h2, 0, 0, 0, 0, 2);
    tick();
    drive_disp(2, 32'h3, 32'h4, 0, 0, 0, 0, 4);
    tick();
    idle_disp();
    chk("s7.slot_pre", iss_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7.async_valid", iss_valid, 0);
    chk("s7.async_count", count, 0);
    chk("s7.async_rob", iss_rob_id, 0);
    tick();
    rst_n = 1'b1;
    iss_ready = 1'b1;
    tick();
    tick();
    chk("s7.no_issue", iss_valid, 0);
    chk("s7.count_end", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
